// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - measures hsync/vsync/de geometry, emits pixel coordinates and a frame lock flag
module vga_timing_rx #(
  parameter int TIMEOUT     = 4095,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [10:0] px,
  output logic [10:0] py,
  output logic        pvalid,
  output logic [10:0] htotal,
  output logic [10:0] hactive,
  output logic [10:0] hsw,
  output logic [10:0] vtotal,
  output logic [10:0] vactive,
  output logic        locked,
  output logic        err
);

  localparam logic [10:0] CMAX   = 11'd2047;
  localparam logic [11:0] TMO    = 12'(TIMEOUT);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  logic        s_h, s_v, s_de, p_h, p_v, p_de;
  logic        h_rise, h_fall, v_rise, de_fall;
  logic [10:0] hc, hw, ha, vc, va, x, y;
  logic [11:0] tmo;
  logic [10:0] htotal_new, vtotal_new, vactive_new;

  state_t      state_q, state_d;
  logic [10:0] ref_h_q, ref_ha_q, ref_v_q, ref_va_q;
  logic [10:0] ref_h_d, ref_ha_d, ref_v_d, ref_va_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic        err_d;

  assign h_rise  = s_h & ~p_h;
  assign h_fall  = ~s_h & p_h;
  assign v_rise  = s_v & ~p_v;
  assign de_fall = ~s_de & p_de;

  // The line ending on this h-rise belongs to the frame closed by a coincident v-rise.
  assign htotal_new  = (hc == CMAX) ? CMAX : hc + 11'd1;
  assign vtotal_new  = (h_rise && vc != CMAX) ? vc + 11'd1 : vc;
  assign vactive_new = (h_rise && ha != 11'd0 && va != CMAX) ? va + 11'd1 : va;

  assign locked = (state_q == LOCKED);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      {s_h, s_v, s_de, p_h, p_v, p_de} <= 6'b0;
      hc <= '0; hw <= '0; ha <= '0; vc <= '0; va <= '0;
      x <= '0; y <= '0; tmo <= '0;
      px <= '0; py <= '0; pvalid <= 1'b0;
      htotal <= '0; hactive <= '0; hsw <= '0; vtotal <= '0; vactive <= '0;
    end else begin
      s_h  <= hsync_in;
      s_v  <= vsync_in;
      s_de <= de_in;
      p_h  <= s_h;
      p_v  <= s_v;
      p_de <= s_de;

      if (h_rise) begin
        hc     <= '0;
        htotal <= htotal_new;
        if (ha != 11'd0) hactive <= ha;
        ha     <= {10'b0, s_de};
      end else begin
        if (hc != CMAX) hc <= hc + 11'd1;
        if (s_de && ha != CMAX) ha <= ha + 11'd1;
      end

      if (h_fall) begin
        hsw <= hw;
        hw  <= '0;
      end else if (s_h && hw != CMAX) begin
        hw <= hw + 11'd1;
      end

      if (v_rise) begin
        vtotal  <= vtotal_new;
        vactive <= vactive_new;
        vc      <= '0;
        va      <= '0;
      end else begin
        vc <= vtotal_new;
        va <= vactive_new;
      end

      if (s_de) begin
        if (x != CMAX) x <= x + 11'd1;
      end else if (de_fall) begin
        x <= '0;
      end

      if (v_rise) y <= '0;
      else if (de_fall && y != CMAX) y <= y + 11'd1;

      px     <= x;
      py     <= y;
      pvalid <= s_de;

      if (h_rise) tmo <= '0;
      else if (tmo != TMO) tmo <= tmo + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= UNLOCKED;
      ref_h_q  <= '0;
      ref_ha_q <= '0;
      ref_v_q  <= '0;
      ref_va_q <= '0;
      mcnt_q   <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_h_q  <= ref_h_d;
      ref_ha_q <= ref_ha_d;
      ref_v_q  <= ref_v_d;
      ref_va_q <= ref_va_d;
      mcnt_q   <= mcnt_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ref_h_d  = ref_h_q;
    ref_ha_d = ref_ha_q;
    ref_v_d  = ref_v_q;
    ref_va_d = ref_va_q;
    mcnt_d   = mcnt_q;
    err_d    = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (v_rise && vtotal_new != 11'd0 && htotal != 11'd0) begin
          ref_h_d  = htotal;
          ref_ha_d = hactive;
          ref_v_d  = vtotal_new;
          ref_va_d = vactive_new;
          mcnt_d   = 4'd1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (v_rise) begin
          if (htotal == ref_h_q && hactive == ref_ha_q &&
              vtotal_new == ref_v_q && vactive_new == ref_va_q) begin
            mcnt_d = mcnt_q + 4'd1;
            if (mcnt_q + 4'd1 >= LOCK_N) state_d = LOCKED;
          end else begin
            ref_h_d  = htotal;
            ref_ha_d = hactive;
            ref_v_d  = vtotal_new;
            ref_va_d = vactive_new;
            mcnt_d   = 4'd1;
          end
        end
      end
      LOCKED: begin
        if ((h_rise && htotal_new != ref_h_q) || (v_rise && vtotal_new != ref_v_q)) begin
          state_d = UNLOCKED;
          err_d   = 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
    // Losing hsync overrides everything else.
    if (tmo == TMO) begin
      state_d = UNLOCKED;
      err_d   = (state_q == LOCKED);
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb/tb_vga_timing_rx.sv - self-checking bench for vga_timing_rx
module tb_vga_timing_rx;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic RST, hsync_in, vsync_in, de_in;
  logic [10:0] px, py, htotal, hactive, hsw, vtotal, vactive;
  logic pvalid, locked, err;

  vga_timing_rx #(.TIMEOUT(TMO), .LOCK_FRAMES(2)) dut (
    .clk(clk), .RST(RST), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .px(px), .py(py), .pvalid(pvalid), .htotal(htotal), .hactive(hactive), .hsw(hsw),
    .vtotal(vtotal), .vactive(vactive), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len; int w; int ds; int dw;
    int exp_ht; int exp_hsw; int exp_ha;
  } vec_t;
  vec_t tbl[5];

  int n_total = 0, n_pass = 0;
  int err_cnt = 0, err_long = 0;
  logic err_prev = 1'b0;
  logic sb_on = 1'b0;
  logic [21:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_px"}, px, 0);
    check({tag, "_py"}, py, 0);
    check({tag, "_pvalid"}, pvalid, 0);
    check({tag, "_htotal"}, htotal, 0);
    check({tag, "_hactive"}, hactive, 0);
    check({tag, "_hsw"}, hsw, 0);
    check({tag, "_vtotal"}, vtotal, 0);
    check({tag, "_vactive"}, vactive, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic cyc(input logic h, input logic v, input logic d);
    hsync_in = h; vsync_in = v; de_in = d;
    @(posedge clk); #1;
  endtask

  task automatic drive_line(input int len, input int w, input int ds, input int dw,
                            input logic vs, input int yline, input logic act, input int chk);
    for (int c = 0; c < len; c++) begin
      logic d;
      d = act && c >= ds && c < ds + dw;
      if (d && sb_on) exp_q.push_back({11'(c - ds), 11'(yline)});
      cyc(c < w, vs, d);
      if (chk >= 0 && c == w + 4) begin
        check($sformatf("tbl%0d_htotal", chk), htotal, tbl[chk].exp_ht);
        check($sformatf("tbl%0d_hsw", chk), hsw, tbl[chk].exp_hsw);
        check($sformatf("tbl%0d_hactive", chk), hactive, tbl[chk].exp_ha);
      end
    end
  endtask

  // 12-line frame: vsync lines 0-1, active lines 3-10, 40-clock lines.
  task automatic drive_frame(input int first, input int glitch);
    for (int l = first; l < 12; l++)
      drive_line((l == glitch) ? 39 : 40, 4, 8, 24, l < 2, l - 3, l >= 3 && l <= 10, -1);
  endtask

  task automatic check_geom(input string tag);
    check({tag, "_htotal"}, htotal, 40);
    check({tag, "_hactive"}, hactive, 24);
    check({tag, "_hsw"}, hsw, 4);
    check({tag, "_vtotal"}, vtotal, 12);
    check({tag, "_vactive"}, vactive, 8);
  endtask

  always @(negedge clk) begin
    if (!RST) begin
      if (err) begin
        err_cnt++;
        if (err_prev) err_long++;
      end
      err_prev = err;
      if (sb_on && pvalid) begin
        if (exp_q.size() == 0) check("pvalid_in_blanking", pvalid, 0);
        else begin
          logic [21:0] e;
          e = exp_q.pop_front();
          check("px", px, e[21:11]);
          check("py", py, e[10:0]);
        end
      end
    end else begin
      err_prev = 1'b0;
    end
  end

  initial begin
    int e0;
    tbl[0] = '{len: 40,   w: 4,  ds: 8,  dw: 24,   exp_ht: 40,   exp_hsw: 4,  exp_ha: 24};
    tbl[1] = '{len: 64,   w: 10, ds: 16, dw: 40,   exp_ht: 64,   exp_hsw: 10, exp_ha: 40};
    tbl[2] = '{len: 30,   w: 2,  ds: 4,  dw: 0,    exp_ht: 30,   exp_hsw: 2,  exp_ha: 40};
    tbl[3] = '{len: 3000, w: 6,  ds: 10, dw: 2100, exp_ht: 2047, exp_hsw: 6,  exp_ha: 2047};
    tbl[4] = '{len: 40,   w: 4,  ds: 8,  dw: 24,   exp_ht: 40,   exp_hsw: 4,  exp_ha: 24};

    RST = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    RST = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive_line(tbl[i].len, tbl[i].w, tbl[i].ds, tbl[i].dw, 1'b0, 0, 1'b1, -1);
      drive_line(tbl[i].len, tbl[i].w, tbl[i].ds, tbl[i].dw, 1'b0, 0, 1'b1, i);
    end

    // Lock-in: a partial preamble, then three full frames.
    e0 = err_cnt;
    drive_frame(9, -1);
    sb_on = 1'b1;
    drive_frame(0, -1);
    drive_frame(0, -1);
    check("locked_before_3rd_vrise", locked, 0);
    drive_frame(0, -1);
    check("locked_after_3rd_vrise", locked, 1);
    check_geom("lockin");
    check("no_err_during_lockin", err_cnt - e0, 0);

    e0 = err_cnt;
    drive_frame(0, 5);
    check("glitch_err_pulses", err_cnt - e0, 1);
    check("glitch_unlocked", locked, 0);
    drive_frame(0, -1);
    drive_frame(0, -1);
    drive_frame(0, -1);
    check("relock_after_glitch", locked, 1);
    check("glitch_no_extra_err", err_cnt - e0, 1);

    sb_on = 1'b0;
    e0 = err_cnt;
    for (int k = 0; k < 1200; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (k == 900)  check("locked_before_timeout", locked, 1);
      if (k == 1000) check("unlocked_after_timeout", locked, 0);
    end
    check("timeout_err_pulses", err_cnt - e0, 1);

    for (int l = 0; l < 5; l++)
      drive_line(40, 4, 8, 24, l < 2, l - 3, l >= 3, -1);
    for (int c = 0; c < 10; c++) cyc(c < 4, 1'b0, c >= 8);
    #2 RST = 1'b1;
    #1 check_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1 RST = 1'b0;
    for (int c = 10; c < 40; c++) cyc(1'b0, 1'b0, c >= 8 && c < 32);
    drive_frame(6, -1);
    sb_on = 1'b1;
    drive_frame(0, -1);
    drive_frame(0, -1);
    check("post_reset_locked_before_3rd", locked, 0);
    drive_frame(0, -1);
    check("post_reset_locked_after_3rd", locked, 1);
    check_geom("post_reset");

    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    sb_on = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);
    check("err_single_clock", err_long, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
